// File: rtl/uart_tx_framed_if.sv
// Host-side word handshake for uart_tx_framed: a word moves on a clock edge
// where tx_send_i (valid) and tx_avbl_i (ready) are both high.
interface uart_tx_framed_if #(
  parameter int WORD_SIZE = 8
) ();
  logic [WORD_SIZE-1:0] data_send;
  logic                 tx_send_i;
  logic                 tx_avbl_i;

  modport master (output data_send, output tx_send_i, input tx_avbl_i);
  modport slave  (input data_send, input tx_send_i, output tx_avbl_i);
endinterface

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: word FIFO feeding a framing FSM with
// configurable width, bit order, parity and stop bits; frames go out back-to-back.
module uart_tx_framed #(
  parameter int WORD_SIZE  = 8,
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  uart_tx_framed_if.slave                    bus,
  output logic                               tx,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic [2:0]                         dbg_state
);
  localparam int BAUD_LIMIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(STOP_BITS * BAUD_LIMIT);
  localparam int NW  = $clog2(WORD_SIZE);
  localparam logic [BCW-1:0] BIT_END  = BCW'(BAUD_LIMIT - 1);
  localparam logic [BCW-1:0] STOP_END = BCW'(STOP_BITS * BAUD_LIMIT - 1);
  localparam logic [NW-1:0]  LAST_BIT = NW'(WORD_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       baud_q, baud_d;
  logic [NW-1:0]        bit_q, bit_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 avbl_q, avbl_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic                 push, pop, load, bit_done;
  logic [WORD_SIZE-1:0] head, shifted;

  function automatic logic out_bit(input logic [WORD_SIZE-1:0] s);
    return (LSB_FIRST != 0) ? s[0] : s[WORD_SIZE-1];
  endfunction

  assign head     = mem_q[rd_ptr_q];
  assign shifted  = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
  assign bit_done = (baud_q == BIT_END);
  assign push     = bus.tx_send_i && avbl_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        load = (count_q != '0);
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = out_bit(shift_q);
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            tx_d    = (PARITY != 0) ? par_q : 1'b1;
          end else begin
            bit_d   = bit_q + NW'(1);
            shift_d = shifted;
            tx_d    = out_bit(shifted);
          end
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == STOP_END) begin
          // A queued word starts its frame on the very next cycle.
          load    = (count_q != '0);
          state_d = S_IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = (^head) ^ (PARITY == 1);
      state_d = S_START;
      baud_d  = '0;
      tx_d    = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    avbl_d   = (count_d < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      avbl_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      avbl_q   <= avbl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_send;
  end

  assign tx            = tx_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign fifo_count    = count_q;
  assign bus.tx_avbl_i = avbl_q;
  assign dbg_state     = state_q;
endmodule
